// File: rtl/sic_mem_responder_if.sv
// Request/response bundle between the SIC CPU word port and the memory responder.
// The master side drives requests; the slave side answers with a completion pulse.
interface sic_mem_responder_if #(
   parameter int ADDRESS_WIDTH = 15,
   parameter int DATA_WIDTH    = 24
);
   logic                     req_valid;
   logic                     req_ready;
   logic                     req_write;
   logic [ADDRESS_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0]    req_wdata;
   logic                     resp_valid;
   logic [DATA_WIDTH-1:0]    resp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/sic_mem_responder.sv
// Word-level responder for the SIC memory port: 24-bit big-endian words moved one
// byte per cycle through a byte-wide store, completion signalled by a resp_valid pulse.
module sic_mem_responder #(
   parameter int ADDRESS_WIDTH = 15,
   parameter int DATA_WIDTH    = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   sic_mem_responder_if.slave  bus
);
   localparam int NUM_BYTES = 3;

   typedef enum logic [2:0] {IDLE, XFER0, XFER1, XFER2, DONE} state_t;

   state_t                   state_reg, state_next;
   logic                     write_reg;
   logic [ADDRESS_WIDTH-1:0] addr_reg;
   logic [DATA_WIDTH-1:0]    wdata_reg;
   logic [15:0]              shadow_reg;
   logic                     ready_reg;
   logic                     resp_valid_reg;
   logic [DATA_WIDTH-1:0]    rdata_reg;
   logic                     accept;

   logic [7:0]               mem [2**ADDRESS_WIDTH];
   logic [7:0]               rd_byte_reg;
   logic [ADDRESS_WIDTH-1:0] mem_raddr;
   logic [ADDRESS_WIDTH-1:0] mem_waddr;
   logic [7:0]               mem_wdata;
   logic                     mem_we;
   logic [1:0]               byte_sel;
   logic [7:0]               wdata_bytes [NUM_BYTES];

   assign accept = bus.req_valid && ready_reg;

   // Byte 0 is the word MSB (big-endian).
   for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_wbytes
      assign wdata_bytes[gi] = wdata_reg[DATA_WIDTH-1-8*gi -: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = XFER0;
         XFER0:   state_next = XFER1;
         XFER1:   state_next = XFER2;
         XFER2:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      byte_sel = 2'd0;
      mem_we   = 1'b0;
      case (state_reg)
         XFER0:   begin byte_sel = 2'd0; mem_we = write_reg; end
         XFER1:   begin byte_sel = 2'd1; mem_we = write_reg; end
         XFER2:   begin byte_sel = 2'd2; mem_we = write_reg; end
         default: begin byte_sel = 2'd0; mem_we = 1'b0;      end
      endcase
   end

   assign mem_waddr = addr_reg + ADDRESS_WIDTH'(byte_sel);
   assign mem_wdata = wdata_bytes[byte_sel];

   // Reads run one byte ahead of the FSM so the registered store output lines up:
   // the accept edge fetches byte a, XFER0 fetches a+1, XFER1 fetches a+2.
   always_comb begin
      case (state_reg)
         IDLE:    mem_raddr = bus.req_addr;
         XFER0:   mem_raddr = addr_reg + ADDRESS_WIDTH'(1);
         XFER1:   mem_raddr = addr_reg + ADDRESS_WIDTH'(2);
         default: mem_raddr = addr_reg;
      endcase
   end

   // Store has no reset so its contents survive rst_n.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      rd_byte_reg <= mem[mem_raddr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_reg      <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         shadow_reg     <= '0;
         ready_reg      <= 1'b1;
         resp_valid_reg <= 1'b0;
         rdata_reg      <= '0;
      end else begin
         ready_reg      <= (state_next == IDLE);
         resp_valid_reg <= (state_reg == XFER2);
         if (accept) begin
            write_reg <= bus.req_write;
            addr_reg  <= bus.req_addr;
            wdata_reg <= bus.req_wdata;
         end
         if (!write_reg) begin
            case (state_reg)
               XFER0:   shadow_reg[15:8] <= rd_byte_reg;
               XFER1:   shadow_reg[7:0]  <= rd_byte_reg;
               XFER2:   rdata_reg        <= {shadow_reg, rd_byte_reg};
               default: ;
            endcase
         end
      end
   end

   assign bus.req_ready  = ready_reg;
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_rdata = rdata_reg;
endmodule

// File: tb/tb_sic_mem_responder.sv
// Directed bench for sic_mem_responder: word writes/reads, wrap, overlap,
// back-pressure, write completion and reset abandoning a transfer.
module tb_sic_mem_responder;
   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   pulse_cnt = 0;
   int   exp_pulses = 0;

   sic_mem_responder_if #(.ADDRESS_WIDTH(15), .DATA_WIDTH(24)) bus ();

   sic_mem_responder #(.ADDRESS_WIDTH(15), .DATA_WIDTH(24)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.resp_valid === 1'b1) pulse_cnt++;
   end

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; runs one full transfer and checks its timing.
   task automatic xfer(input string tag, input logic wr, input logic [14:0] a,
                       input logic [23:0] wd, input logic [23:0] exp, input logic [23:0] mask);
      int waitc = 0;
      while (bus.req_ready !== 1'b1 && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      check({tag, " ready"}, 24'(bus.req_ready), 24'd1);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check({tag, " no early resp"}, 24'(bus.resp_valid), 24'd0);
      @(negedge clk);
      check({tag, " resp_valid"}, 24'(bus.resp_valid), 24'd1);
      check({tag, " rdata"}, bus.resp_rdata & mask, exp & mask);
      exp_pulses++;
      @(negedge clk);
      check({tag, " resp drop"}, 24'(bus.resp_valid), 24'd0);
      check({tag, " ready back"}, 24'(bus.req_ready), 24'd1);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      repeat (3) @(negedge clk);
      check("reset ready", 24'(bus.req_ready), 24'd1);
      check("reset resp_valid", 24'(bus.resp_valid), 24'd0);
      check("reset rdata", bus.resp_rdata, 24'h000000);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle ready", 24'(bus.req_ready), 24'd1);

      xfer("wr 0030", 1'b1, 15'h0030, 24'h123456, 24'h000000, 24'hFFFFFF);
      xfer("rd 0030", 1'b0, 15'h0030, 24'h0, 24'h123456, 24'hFFFFFF);
      xfer("wr 7FFE keeps rdata", 1'b1, 15'h7FFE, 24'hABCDEF, 24'h123456, 24'hFFFFFF);
      xfer("rd 7FFE wrap", 1'b0, 15'h7FFE, 24'h0, 24'hABCDEF, 24'hFFFFFF);
      xfer("rd 0000 wrapped byte", 1'b0, 15'h0000, 24'h0, 24'hEF0000, 24'hFF0000);
      xfer("rd 0031 unaligned", 1'b0, 15'h0031, 24'h0, 24'h345600, 24'hFFFF00);
      xfer("wr 0100", 1'b1, 15'h0100, 24'h111111, 24'h345600, 24'hFFFF00);
      xfer("wr 0101", 1'b1, 15'h0101, 24'h222222, 24'h345600, 24'hFFFF00);

      // Back-pressure: a second read is held on the bus throughout the first.
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 15'h0100;
      @(posedge clk);
      #1 bus.req_addr = 15'h0030;
      @(negedge clk);
      check("bp ready XFER0", 24'(bus.req_ready), 24'd0);
      @(negedge clk);
      check("bp ready XFER1", 24'(bus.req_ready), 24'd0);
      @(negedge clk);
      check("bp ready XFER2", 24'(bus.req_ready), 24'd0);
      @(negedge clk);
      check("bp ready DONE", 24'(bus.req_ready), 24'd0);
      check("bp first resp", 24'(bus.resp_valid), 24'd1);
      check("bp overlap rdata", bus.resp_rdata, 24'h112222);
      exp_pulses++;
      @(negedge clk);
      check("bp ready IDLE", 24'(bus.req_ready), 24'd1);
      check("bp resp drop", 24'(bus.resp_valid), 24'd0);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("bp second no early resp", 24'(bus.resp_valid), 24'd0);
      @(negedge clk);
      check("bp second resp", 24'(bus.resp_valid), 24'd1);
      check("bp second rdata", bus.resp_rdata, 24'h123456);
      exp_pulses++;
      @(negedge clk);
      check("bp second resp drop", 24'(bus.resp_valid), 24'd0);

      // Reset during XFER1 of a write: only byte 0x0030 has been stored.
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 15'h0030;
      bus.req_wdata = 24'h999999;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset ready", 24'(bus.req_ready), 24'd1);
      check("midreset resp_valid", 24'(bus.resp_valid), 24'd0);
      check("midreset rdata", bus.resp_rdata, 24'h000000);
      @(negedge clk);
      check("midreset held resp", 24'(bus.resp_valid), 24'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post reset no resp", 24'(bus.resp_valid), 24'd0);
      xfer("rd 0030 after abort", 1'b0, 15'h0030, 24'h0, 24'h993456, 24'hFFFFFF);

      repeat (3) @(negedge clk);
      check("pulse count", 24'(pulse_cnt), 24'(exp_pulses));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
